// File: rtl/clk_gen_multi_pkg.sv
// Shared definitions for the multi-channel clock/tick generator: defaults,
// the minimum usable period and the channel-index width helper.
package clk_gen_multi_pkg;

  localparam int CNT_W_DEFAULT = 24;
  localparam int MIN_DIV       = 2;

  // What a channel counter does on the next clock edge.
  typedef enum logic [1:0] {
    OP_RUN,      // count up
    OP_WRAP,     // last cycle of the period: back to 0, shadow may be applied
    OP_RESTART   // sync or disabled: back to 0, shadow applied immediately
  } chan_op_e;

  // Width of a channel index; a single channel still gets one select bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_multi_chan.sv
// One divider channel: period counter, shadow {div, high} with pending flag,
// and registered clk_out / tick outputs.
module clk_gen_multi_chan
  import clk_gen_multi_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV  = 13500000,
  parameter int DEFAULT_HIGH = 6750000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_eff;
  chan_op_e         op;

  always_comb begin
    // Periods below 2 cannot produce a tick and a gap, so they are clamped.
    div_eff = (div_q < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_q;

    if (sync || !en) begin
      op = OP_RESTART;
    end else if (cnt_q == div_eff - CNT_W'(1)) begin
      op = OP_WRAP;
    end else begin
      op = OP_RUN;
    end

    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    sh_div_d  = sh_div_q;
    sh_high_d = sh_high_q;
    pend_d    = pend_q;

    case (op)
      OP_RUN: cnt_d = cnt_q + CNT_W'(1);
      default: begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = sh_div_q;
          high_d = sh_high_q;
          pend_d = 1'b0;
        end
      end
    endcase

    // The top only raises wr_en while pending is clear, so this never
    // collides with an apply in the same cycle.
    if (wr_en) begin
      sh_div_d  = wr_div;
      sh_high_d = wr_high;
      pend_d    = 1'b1;
    end

    clk_out_d = en && (cnt_q < high_q);
    tick_d    = en && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      high_q    <= CNT_W'(DEFAULT_HIGH);
      sh_div_q  <= '0;
      sh_high_q <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sh_div_q  <= sh_div_d;
      sh_high_q <= sh_high_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH programmable clock/tick generators on one system clock, with a
// valid/ready config port per channel and a global phase-aligning sync.
module clk_gen_multi
  import clk_gen_multi_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  CNT_W        = CNT_W_DEFAULT,
  parameter int  DEFAULT_DIV  = 13500000,
  parameter int  DEFAULT_HIGH = 6750000,
  localparam int CH_W         = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0]      pend;
  logic [(1<<CH_W)-1:0]   pend_ext;
  logic                   cfg_fire;

  // Unused index codes read as "not pending", so writes to them are
  // accepted and dropped because no channel decodes them.
  always_comb begin
    pend_ext             = '0;
    pend_ext[NUM_CH-1:0] = pend;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];
  assign cfg_fire  = cfg_valid & cfg_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic wr_en;
      assign wr_en = cfg_fire && (cfg_ch == CH_W'(gi));

      clk_gen_multi_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .DEFAULT_HIGH(DEFAULT_HIGH)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .en     (en[gi]),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_div (cfg_div),
        .wr_high(cfg_high),
        .pending(pend[gi]),
        .clk_out(clk_out[gi]),
        .tick   (tick[gi])
      );
    end
  endgenerate

endmodule
